cursor_ctrl: RTL

- Moves the on-screen cursor from four board push-buttons.
- Synchronises and debounces the buttons, then runs a press / hold / auto-repeat state machine.
- Commits position changes only on the frame tick at the start of vertical blanking, so the cursor never tears mid-frame.
- Drives the top-left coordinate consumed by the cursor-drawing logic that feeds the VGA pixel path.

---
 rtl/cursor_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/cursor_ctrl.sv
// Cursor position controller: four debounced push-buttons drive a press/hold/auto-repeat
// state machine whose position updates are committed only on the vblank frame tick.
module cursor_ctrl #(
   parameter int H_ACTIVE        = 640,
   parameter int V_ACTIVE        = 480,
   parameter int CURSOR_W        = 16,
   parameter int CURSOR_H        = 16,
   parameter int STEP            = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 30,
   parameter int REPEAT_RATE     = 4
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        frame_tick,
   output logic [10:0] cursor_x,
   output logic [10:0] cursor_y,
   output logic        moved
);

   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int FC_W    = $clog2(CNT_MAX + 1);

   localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_ONE     = DB_W'(1);
   localparam logic [FC_W-1:0] DELAY_LAST = FC_W'(REPEAT_DELAY - 1);
   localparam logic [FC_W-1:0] RATE_LAST  = FC_W'(REPEAT_RATE - 1);
   localparam logic [FC_W-1:0] FC_ONE     = FC_W'(1);

   localparam logic [10:0] X_MAX = 11'(H_ACTIVE - CURSOR_W);
   localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - CURSOR_H);
   localparam logic [10:0] X_RST = 11'((H_ACTIVE - CURSOR_W) / 2);
   localparam logic [10:0] Y_RST = 11'((V_ACTIVE - CURSOR_H) / 2);

   localparam logic signed [11:0] STEP_S   = 12'(STEP);
   localparam logic signed [1:0]  DIR_POS  = 2'sd1;
   localparam logic signed [1:0]  DIR_NEG  = -2'sd1;
   localparam logic signed [1:0]  DIR_ZERO = 2'sd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_DELAY,
      S_REPEAT
   } state_t;

   // Button bit order: 0 = up, 1 = down, 2 = left, 3 = right.
   logic [3:0] btn_raw;
   assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

   logic [3:0]      sync1_d, sync1_q;
   logic [3:0]      sync2_d, sync2_q;
   logic [3:0]      lvl_d, lvl_q;
   logic [DB_W-1:0] db_cnt_d [4];
   logic [DB_W-1:0] db_cnt_q [4];

   state_t             state_d, state_q;
   logic [FC_W-1:0]    frame_cnt_d, frame_cnt_q;
   logic signed [1:0]  dx_lat_d, dx_lat_q;
   logic signed [1:0]  dy_lat_d, dy_lat_q;
   logic [10:0]        cursor_x_d, cursor_x_q;
   logic [10:0]        cursor_y_d, cursor_y_q;
   logic               moved_d, moved_q;

   logic               active;
   logic signed [1:0]  dx, dy;
   logic signed [1:0]  step_dx, step_dy;
   logic               do_step;
   logic [10:0]        nx, ny;

   // Per-button synchroniser and debouncer; any agreement with the current level
   // restarts that button's counter.
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      lvl_d   = lvl_q;
      for (int i = 0; i < 4; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != lvl_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               lvl_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
            end
         end
      end
   end

   always_comb begin
      dx = DIR_ZERO;
      dy = DIR_ZERO;
      if (lvl_q[3] && !lvl_q[2]) dx = DIR_POS;
      else if (lvl_q[2] && !lvl_q[3]) dx = DIR_NEG;
      if (lvl_q[1] && !lvl_q[0]) dy = DIR_POS;
      else if (lvl_q[0] && !lvl_q[1]) dy = DIR_NEG;
      active = |lvl_q;
   end

   function automatic logic [10:0] clamp_step(input logic [10:0] pos,
                                              input logic signed [1:0] dir,
                                              input logic [10:0] max_pos);
      logic signed [11:0] delta;
      logic signed [11:0] n;
      delta = (dir == DIR_POS) ? STEP_S : (dir == DIR_NEG) ? -STEP_S : 12'sd0;
      n = $signed({1'b0, pos}) + delta;
      if (n[11]) return '0;
      else if (n > $signed({1'b0, max_pos})) return max_pos;
      else return n[10:0];
   endfunction

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      dx_lat_d    = dx_lat_q;
      dy_lat_d    = dy_lat_q;
      do_step     = 1'b0;
      step_dx     = dx;
      step_dy     = dy;
      case (state_q)
         S_IDLE: begin
            if (active) begin
               dx_lat_d = dx;
               dy_lat_d = dy;
               state_d  = S_ARMED;
            end
         end
         // The latched direction guarantees a short press still moves once.
         S_ARMED: begin
            if (frame_tick) begin
               do_step     = 1'b1;
               step_dx     = dx_lat_q;
               step_dy     = dy_lat_q;
               frame_cnt_d = '0;
               state_d     = active ? S_DELAY : S_IDLE;
            end
         end
         S_DELAY: begin
            if (!active) begin
               frame_cnt_d = '0;
               state_d     = S_IDLE;
            end else if (frame_tick) begin
               if (frame_cnt_q == DELAY_LAST) begin
                  do_step     = 1'b1;
                  frame_cnt_d = '0;
                  state_d     = S_REPEAT;
               end else begin
                  frame_cnt_d = frame_cnt_q + FC_ONE;
               end
            end
         end
         S_REPEAT: begin
            if (!active) begin
               frame_cnt_d = '0;
               state_d     = S_IDLE;
            end else if (frame_tick) begin
               if (frame_cnt_q == RATE_LAST) begin
                  do_step     = 1'b1;
                  frame_cnt_d = '0;
               end else begin
                  frame_cnt_d = frame_cnt_q + FC_ONE;
               end
            end
         end
         default: begin
            frame_cnt_d = '0;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_comb begin
      nx         = clamp_step(cursor_x_q, step_dx, X_MAX);
      ny         = clamp_step(cursor_y_q, step_dy, Y_MAX);
      cursor_x_d = cursor_x_q;
      cursor_y_d = cursor_y_q;
      moved_d    = 1'b0;
      if (do_step) begin
         cursor_x_d = nx;
         cursor_y_d = ny;
         moved_d    = (nx != cursor_x_q) || (ny != cursor_y_q);
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         lvl_q       <= '0;
         for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
         state_q     <= S_IDLE;
         frame_cnt_q <= '0;
         dx_lat_q    <= DIR_ZERO;
         dy_lat_q    <= DIR_ZERO;
         cursor_x_q  <= X_RST;
         cursor_y_q  <= Y_RST;
         moved_q     <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         lvl_q       <= lvl_d;
         for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         dx_lat_q    <= dx_lat_d;
         dy_lat_q    <= dy_lat_d;
         cursor_x_q  <= cursor_x_d;
         cursor_y_q  <= cursor_y_d;
         moved_q     <= moved_d;
      end
   end

   assign cursor_x = cursor_x_q;
   assign cursor_y = cursor_y_q;
   assign moved    = moved_q;

endmodule
